db_sensor_view: RTL and testbench
=================================

Name: db_sensor_view

Overview:
- Board-level debug front end for sensor controllers: debounces push-buttons, issues one-shot command codes, and pages multi-channel sensor values onto a bank of LEDs.
- Generalised successor of the single-sensor LED viewer:
  - parametrised channel count, value width and page width;
  - adds a debounced command strobe and an auto-scroll display mode.
- Sits between board I/O (keys, switches, LEDs) and a sensor top such as the BMP180 controller.

Parameters:
- FPGA_CLK, 50_000_000, system clock frequency in Hz
- CH_NUM, 2, number of sensor channels
- DATA_W, 19, width of each channel value
- PAGE_W, 8, data bits shown per LED page
- DB_MS, 10, debounce stable time in ms
- SCROLL_MS, 1000, auto-scroll page period in ms

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- I_KEY_COMM  in  1  raw command push-button, active-low
- I_KEY_MODE  in  1  raw mode push-button, active-low
- I_SW_COMM  in  4  command code
- I_SEL  in  SEL_W  manual page select; SEL_W = $clog2(TOTAL), TOTAL = CH_NUM*PAGES, PAGES = ceil(DATA_W/PAGE_W)
- I_DATA  in  CH_NUM*DATA_W  packed channel values, channel 0 in the LSBs
- I_ACK  in  1  controller ack flag
- I_ERR  in  1  controller error flag
- O_COMM  out  4  command code, valid for one cycle per accepted press, otherwise 0
- O_LEDR  out  PAGE_W+2  {err, ack, page data}
- O_PAGE  out  SEL_W  page currently displayed
- O_AUTO  out  1  1 = auto-scroll mode

Behaviour:
- Reset:
  - all outputs 0; manual mode.
  - key synchronisers, debounced key states and the two press-edge trackers (last-accepted state per key) preset to released (1).
  - all counters 0.
- RST has priority over all other activity; asserting it mid-operation aborts debounce and scroll immediately.
- Key path, per key, keys independent:
  - 2-FF synchroniser.
  - Debounce counter of DB_CYC = (FPGA_CLK/1000)*DB_MS cycles. It counts while the synced level differs from the debounced state and clears on any match.
  - When it reaches DB_CYC-1, the debounced state takes the new level.
  - A press is a debounced 1->0 transition. Releases produce nothing.
- A key held through reset release fires exactly once after DB_CYC+2 cycles.
- Command:
  - on an accepted COMM press, O_COMM = I_SW_COMM, sampled in that cycle, for exactly one cycle; otherwise 4'b0.
  - holding the key gives no repeat.
- Mode: an accepted MODE press toggles O_AUTO.
  - Entering auto: page counter := 0, scroll timer := 0.
  - Leaving auto: page source reverts to I_SEL on the next cycle.
- Simultaneous COMM and MODE presses in the same cycle are both served.
- Auto scroll:
  - timer counts SCROLL_CYC = (FPGA_CLK/1000)*SCROLL_MS cycles;
  - at SCROLL_CYC-1 it clears and the page increments, wrapping TOTAL-1 -> 0.
- Page source: O_PAGE = auto ? page counter : I_SEL, registered, 1-cycle latency.
- Page decode, for page p:
  - ch = p / PAGES, j = p % PAGES.
  - The channel value is zero-extended on the left to PAGES*PAGE_W bits.
  - j = 0 selects the most significant slice; the partial top slice is right-aligned with zero fill.
  - p >= TOTAL (manual only): data field = 0, flag bits still shown.
- O_LEDR = {I_ERR, I_ACK, slice}, registered; updates 1 cycle after I_SEL, I_DATA or flag change.
- Width rules: all counters are sized by $clog2 of their terminal count. Data is treated as raw bits, with no sign extension.

Optional Feature:
- Macro: DB_STICKY_ERR_EN
- Defined:
  - the err LED bit is a sticky latch, set by I_ERR = 1 and cleared only by RST or by an accepted COMM press;
  - when clear and set occur in the same cycle, set wins.
- Undefined: the err LED bit follows I_ERR with 1-cycle latency.

Test Plan:
Common settings: FPGA_CLK=10_000, DB_MS=2 (DB_CYC=20), SCROLL_MS=5 (SCROLL_CYC=50), CH_NUM=2, DATA_W=19, PAGE_W=8. Channel 0 = 19'h12345, channel 1 = 19'h5A5C3, I_ACK=1, I_ERR=0.
- Manual paging: I_SEL=0,1,2,3,4,5,6 -> O_LEDR = 0x101, 0x123, 0x145, 0x105, 0x1A5, 0x1C3, 0x100, each 1 cycle after I_SEL changes.
- Command: I_SW_COMM=4'hA, COMM key low for 40 cycles -> O_COMM=4'hA for exactly one cycle, 22 cycles after the falling edge; no pulse on release.
- Bounce: key toggles every 5 cycles for 60 cycles, then stays high -> O_COMM stays 0 throughout.
- Auto scroll: MODE press -> O_AUTO=1, O_PAGE=0; O_PAGE steps by 1 every 50 cycles, 5 -> 0 wrap. A second press -> O_AUTO=0 and O_PAGE=I_SEL.
- Reset mid-scroll: RST high for 1 cycle at page 3 -> all outputs 0, O_AUTO=0 on the next cycle.
- Sticky error (macro defined): I_ERR pulsed for 1 cycle -> LED bit 9 stays 1; an accepted COMM press clears it. Without the macro, bit 9 falls 1 cycle after I_ERR falls.

Source files
------------

// File: rtl/db_sensor_view.sv
// Purpose : debounced key front end plus paged LED viewer for multi-channel sensor values.
// Latency : O_COMM fires DB_CYC+2 cycles after a key goes low; O_LEDR/O_PAGE lag their sources by 1 cycle.
// Backpr. : none; board I/O is sampled every cycle and outputs are plain registers.
//
// Ports:
//   CLK, RST            system clock, synchronous active-high reset
//   I_KEY_COMM/I_KEY_MODE  raw active-low push-buttons
//   I_SW_COMM [3:0]     command code, captured on an accepted COMM press
//   I_SEL [SEL_W-1:0]   manual page select
//   I_DATA              CH_NUM packed channel values, channel 0 in the LSBs
//   I_ACK, I_ERR        controller status flags shown on the top two LEDs
//   O_COMM [3:0]        one-cycle command pulse, otherwise 0
//   O_LEDR              {err, ack, page slice}
//   O_PAGE              page currently displayed
//   O_AUTO              1 while auto-scroll mode is active
// Build option: define DB_STICKY_ERR_EN to make the err LED a sticky latch
// (set by I_ERR, cleared by RST or an accepted COMM press, set wins).
module db_sensor_view #(
   parameter int FPGA_CLK  = 50_000_000,
   parameter int CH_NUM    = 2,
   parameter int DATA_W    = 19,
   parameter int PAGE_W    = 8,
   parameter int DB_MS     = 10,
   parameter int SCROLL_MS = 1000,
   localparam int PAGES    = (DATA_W + PAGE_W - 1) / PAGE_W,
   localparam int TOTAL    = CH_NUM * PAGES,
   localparam int SEL_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     I_KEY_COMM,
   input  logic                     I_KEY_MODE,
   input  logic [3:0]               I_SW_COMM,
   input  logic [SEL_W-1:0]         I_SEL,
   input  logic [CH_NUM*DATA_W-1:0] I_DATA,
   input  logic                     I_ACK,
   input  logic                     I_ERR,
   output logic [3:0]               O_COMM,
   output logic [PAGE_W+1:0]        O_LEDR,
   output logic [SEL_W-1:0]         O_PAGE,
   output logic                     O_AUTO
);

   localparam int DB_CYC     = (FPGA_CLK / 1000) * DB_MS;
   localparam int SCROLL_CYC = (FPGA_CLK / 1000) * SCROLL_MS;
   localparam int DB_W       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
   localparam int SC_W       = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
   localparam int EXT_W      = PAGES * PAGE_W;

   // Key path: index 0 = COMM, index 1 = MODE
   logic [1:0]      key_raw;
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      db;
   logic [1:0]      last;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];

   assign key_raw = {I_KEY_MODE, I_KEY_COMM};

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1 <= '1;
         sync2 <= '1;
         db    <= '1;
         last  <= '1;
         for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         last  <= db;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == db[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_W'(DB_CYC - 2)) begin
               // the increment would reach DB_CYC-1: accept the new level
               db[k]     <= sync2[k];
               db_cnt[k] <= '0;
            end else begin
               db_cnt[k] <= db_cnt[k] + 1'b1;
            end
         end
      end
   end

   // A press is a debounced 1->0 step; releases are ignored
   assign press = last & ~db;

   // Page slice table: each channel zero-extended to EXT_W bits,
   // slice j=0 is the most significant (partial) one
   logic [PAGE_W-1:0] slice_tab [TOTAL];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic [EXT_W-1:0] ext;
      assign ext = EXT_W'(I_DATA[c*DATA_W +: DATA_W]);
      for (genvar j = 0; j < PAGES; j++) begin : g_pg
         assign slice_tab[c*PAGES + j] = ext[(PAGES-1-j)*PAGE_W +: PAGE_W];
      end
   end

   logic [SEL_W-1:0]  page_cnt;
   logic [SC_W-1:0]   scr_cnt;
   logic [SEL_W-1:0]  page_src;
   logic [PAGE_W-1:0] slice_sel;
   logic              err_nxt;

   always_comb begin
      page_src  = O_AUTO ? page_cnt : I_SEL;
      slice_sel = '0;
      // manual selects beyond the last page show an empty data field
      if (int'(page_src) < TOTAL) slice_sel = slice_tab[page_src];
   end

`ifdef DB_STICKY_ERR_EN
   assign err_nxt = I_ERR | (O_LEDR[PAGE_W+1] & ~press[0]);
`else
   assign err_nxt = I_ERR;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         O_COMM   <= '0;
         O_LEDR   <= '0;
         O_PAGE   <= '0;
         O_AUTO   <= 1'b0;
         page_cnt <= '0;
         scr_cnt  <= '0;
      end else begin
         O_COMM <= press[0] ? I_SW_COMM : 4'h0;
         O_PAGE <= page_src;
         O_LEDR <= {err_nxt, I_ACK, slice_sel};
         if (press[1]) begin
            // toggling always restarts the scroll from page 0
            O_AUTO   <= ~O_AUTO;
            page_cnt <= '0;
            scr_cnt  <= '0;
         end else if (O_AUTO) begin
            if (scr_cnt == SC_W'(SCROLL_CYC - 1)) begin
               scr_cnt  <= '0;
               page_cnt <= (page_cnt == SEL_W'(TOTAL - 1)) ? '0 : page_cnt + 1'b1;
            end else begin
               scr_cnt <= scr_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_db_sensor_view.sv
module tb_db_sensor_view;

   logic        CLK;
   logic        RST;
   logic        I_KEY_COMM;
   logic        I_KEY_MODE;
   logic [3:0]  I_SW_COMM;
   logic [2:0]  I_SEL;
   logic [37:0] I_DATA;
   logic        I_ACK;
   logic        I_ERR;
   logic [3:0]  O_COMM;
   logic [9:0]  O_LEDR;
   logic [2:0]  O_PAGE;
   logic        O_AUTO;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      logic [3:0] code;
      int         at;
   } comm_exp_t;
   comm_exp_t comm_q[$];

   typedef struct {
      logic [9:0] ledr;
      logic [2:0] page;
   } pg_exp_t;
   pg_exp_t pg_q[$];

   logic [9:0] ledr_tab [7];

   db_sensor_view #(
      .FPGA_CLK(10_000), .CH_NUM(2), .DATA_W(19), .PAGE_W(8),
      .DB_MS(2), .SCROLL_MS(5)
   ) dut (
      .CLK(CLK), .RST(RST),
      .I_KEY_COMM(I_KEY_COMM), .I_KEY_MODE(I_KEY_MODE),
      .I_SW_COMM(I_SW_COMM), .I_SEL(I_SEL), .I_DATA(I_DATA),
      .I_ACK(I_ACK), .I_ERR(I_ERR),
      .O_COMM(O_COMM), .O_LEDR(O_LEDR), .O_PAGE(O_PAGE), .O_AUTO(O_AUTO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step(1);
   endtask

   // Command monitor: every nonzero O_COMM must match the next queued press
   always @(negedge CLK) begin
      if (!RST && O_COMM !== 4'h0) begin
         if (comm_q.size() == 0) begin
            checks++;
            assert (O_COMM === 4'h0) else begin
               fails++;
               $error("FAIL comm_unexpected observed=%0h expected=0 cyc=%0d", O_COMM, cyc);
            end
         end else begin
            comm_exp_t e;
            e = comm_q.pop_front();
            checks += 2;
            assert (O_COMM === e.code) else begin
               fails++;
               $error("FAIL comm_code observed=%0h expected=%0h", O_COMM, e.code);
            end
            assert (cyc == e.at) else begin
               fails++;
               $error("FAIL comm_cycle observed=%0d expected=%0d", cyc, e.at);
            end
         end
      end
   end

   initial begin
      int c0;
      int k;
      pg_exp_t pe;
      comm_exp_t ce;

      ledr_tab[0] = 10'h101; ledr_tab[1] = 10'h123; ledr_tab[2] = 10'h145;
      ledr_tab[3] = 10'h105; ledr_tab[4] = 10'h1A5; ledr_tab[5] = 10'h1C3;
      ledr_tab[6] = 10'h100;

      RST = 1'b1; I_KEY_COMM = 1'b1; I_KEY_MODE = 1'b1; I_SW_COMM = 4'h3;
      I_SEL = 3'd0; I_DATA = {19'h5A5C3, 19'h12345}; I_ACK = 1'b1; I_ERR = 1'b0;
      step(3);
      check("rst_comm", 32'(O_COMM), 32'h0);
      check("rst_ledr", 32'(O_LEDR), 32'h0);
      check("rst_page", 32'(O_PAGE), 32'h0);
      check("rst_auto", 32'(O_AUTO), 32'h0);
      RST = 1'b0;
      step(2);

      // Manual paging, including the out-of-range select 6
      for (int i = 0; i <= 6; i++) begin
         I_SEL = 3'(i);
         pe.ledr = ledr_tab[i];
         pe.page = 3'(i);
         pg_q.push_back(pe);
         if (i > 0) begin
            #2;
            check("page_hold", 32'(O_LEDR), 32'(ledr_tab[i-1]));
         end
         step(1);
         pe = pg_q.pop_front();
         check($sformatf("page_ledr%0d", i), 32'(O_LEDR), 32'(pe.ledr));
         check($sformatf("page_sel%0d", i), 32'(O_PAGE), 32'(pe.page));
      end

      // Data change: all-ones channel 0 shows the partial top slice right-aligned
      I_SEL = 3'd0; I_DATA = {19'h5A5C3, 19'h7FFFF};
      pe.ledr = 10'h107; pe.page = 3'd0; pg_q.push_back(pe);
      step(1);
      pe = pg_q.pop_front();
      check("data_top", 32'(O_LEDR), 32'(pe.ledr));
      I_SEL = 3'd2;
      pe.ledr = 10'h1FF; pe.page = 3'd2; pg_q.push_back(pe);
      step(1);
      pe = pg_q.pop_front();
      check("data_low", 32'(O_LEDR), 32'(pe.ledr));
      I_DATA = {19'h5A5C3, 19'h12345};
      step(1);

      // Command press: code changes mid-debounce, the press-cycle value is used
      c0 = cyc;
      I_KEY_COMM = 1'b0;
      ce.code = 4'hA; ce.at = c0 + 22; comm_q.push_back(ce);
      step(10);
      I_SW_COMM = 4'hA;
      run_to(c0 + 21);
      check("comm_early", 32'(O_COMM), 32'h0);
      run_to(c0 + 22);
      check("comm_pulse", 32'(O_COMM), 32'hA);
      run_to(c0 + 23);
      check("comm_one", 32'(O_COMM), 32'h0);
      run_to(c0 + 40);
      I_KEY_COMM = 1'b1;
      step(40);
      check("comm_release", 32'(comm_q.size()), 32'h0);

      // Bouncing key: never stable long enough to be accepted
      for (int i = 0; i < 12; i++) begin
         I_KEY_COMM = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(5);
      end
      I_KEY_COMM = 1'b1;
      step(40);
      check("bounce_none", 32'(comm_q.size()), 32'h0);

      // Error LED behaviour
      I_ERR = 1'b1;
      step(1);
      check("err_set", 32'(O_LEDR[9]), 32'h1);
      I_ERR = 1'b0;
      step(1);
`ifdef DB_STICKY_ERR_EN
      check("err_after", 32'(O_LEDR[9]), 32'h1);
      step(5);
      check("err_hold", 32'(O_LEDR[9]), 32'h1);
`else
      check("err_after", 32'(O_LEDR[9]), 32'h0);
      step(5);
      check("err_hold", 32'(O_LEDR[9]), 32'h0);
`endif
      c0 = cyc;
      I_SW_COMM = 4'h5;
      I_KEY_COMM = 1'b0;
      ce.code = 4'h5; ce.at = c0 + 22; comm_q.push_back(ce);
      run_to(c0 + 21);
`ifdef DB_STICKY_ERR_EN
      check("err_pre_clr", 32'(O_LEDR[9]), 32'h1);
`else
      check("err_pre_clr", 32'(O_LEDR[9]), 32'h0);
`endif
      run_to(c0 + 22);
      check("err_clr", 32'(O_LEDR[9]), 32'h0);
      run_to(c0 + 30);
      I_KEY_COMM = 1'b1;
      step(40);

      // Auto scroll
      I_SEL = 3'd4;
      c0 = cyc;
      I_KEY_MODE = 1'b0;
      k = c0 + 22;
      run_to(k - 1);
      check("auto_early", 32'(O_AUTO), 32'h0);
      run_to(k);
      check("auto_on", 32'(O_AUTO), 32'h1);
      check("auto_page_lag", 32'(O_PAGE), 32'h4);
      run_to(k + 1);
      check("auto_page0", 32'(O_PAGE), 32'h0);
      check("auto_ledr0", 32'(O_LEDR), 32'(ledr_tab[0]));
      I_KEY_MODE = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         run_to(k + 50 * n);
         check($sformatf("scroll_hold%0d", n), 32'(O_PAGE), 32'((n - 1) % 6));
         run_to(k + 50 * n + 1);
         check($sformatf("scroll_page%0d", n), 32'(O_PAGE), 32'(n % 6));
         check($sformatf("scroll_ledr%0d", n), 32'(O_LEDR), 32'(ledr_tab[n % 6]));
      end

      // Leave auto: page source reverts to I_SEL
      c0 = cyc;
      I_KEY_MODE = 1'b0;
      run_to(c0 + 21);
      check("auto_still", 32'(O_AUTO), 32'h1);
      run_to(c0 + 22);
      check("auto_off", 32'(O_AUTO), 32'h0);
      run_to(c0 + 23);
      check("manual_page", 32'(O_PAGE), 32'h4);
      check("manual_ledr", 32'(O_LEDR), 32'h1A5);
      run_to(c0 + 25);
      I_KEY_MODE = 1'b1;
      step(30);

      // Reset in the middle of scrolling
      c0 = cyc;
      I_KEY_MODE = 1'b0;
      k = c0 + 22;
      run_to(k + 1);
      I_KEY_MODE = 1'b1;
      run_to(k + 151);
      check("mid_page3", 32'(O_PAGE), 32'h3);
      check("mid_auto", 32'(O_AUTO), 32'h1);
      RST = 1'b1;
      step(1);
      check("mid_rst_ledr", 32'(O_LEDR), 32'h0);
      check("mid_rst_page", 32'(O_PAGE), 32'h0);
      check("mid_rst_auto", 32'(O_AUTO), 32'h0);
      check("mid_rst_comm", 32'(O_COMM), 32'h0);
      RST = 1'b0;
      step(1);
      check("post_rst_page", 32'(O_PAGE), 32'h4);
      check("post_rst_ledr", 32'(O_LEDR), 32'h1A5);
      check("post_rst_auto", 32'(O_AUTO), 32'h0);
      step(60);
      check("post_rst_auto_hold", 32'(O_AUTO), 32'h0);
      check("comm_drained", 32'(comm_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
